// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file widths, address type and writeback scheduler states.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NREGS = 32;
  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef enum logic {NORMAL, HOLD} wb_state_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bits and outstanding-op count for long-latency writebacks, plus decode hazard detection.
module rf_scoreboard #(
  parameter int NREGS = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              iss_valid,
  input  rv_pkg::reg_addr_t iss_rd,
  output logic              iss_ready,
  input  logic              lsu_grant,
  input  rv_pkg::reg_addr_t lsu_waddr,
  output logic              lsu_busy,
  input  rv_pkg::reg_addr_t dec_rs1,
  input  rv_pkg::reg_addr_t dec_rs2,
  input  rv_pkg::reg_addr_t dec_rd,
  output logic              dec_stall
);
  import rv_pkg::*;
  localparam int CW = $clog2(MAX_OUTST + 1);
  logic [NREGS-1:0] busy_q, busy_d, eff_busy;
  logic [CW-1:0]    outst_q, outst_d;
  logic             iss_acc;
  always_comb begin
    iss_ready = (outst_q < CW'(MAX_OUTST)) || lsu_grant;
    iss_acc = iss_valid && iss_ready;
    busy_d = busy_q;
    if (lsu_grant) busy_d[lsu_waddr] = 1'b0;
    if (iss_acc) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    outst_d = outst_q + CW'(iss_acc) - CW'(lsu_grant && outst_q != '0);
    eff_busy = busy_q & ~(lsu_grant ? (NREGS'(1) << lsu_waddr) : '0);
    dec_stall = eff_busy[dec_rs1] | eff_busy[dec_rs2] | eff_busy[dec_rd];
    lsu_busy = busy_q[lsu_waddr];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      busy_q <= '0;
      outst_q <= '0;
    end else begin
      busy_q <= busy_d;
      outst_q <= outst_d;
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: merges ALU and long-latency writebacks onto the single regfile write port,
// forcing a one-cycle pipeline hold when the long-latency unit has been starved too long.
module regfile_wb_sched #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_we,
  input  rv_pkg::reg_addr_t alu_waddr,
  input  logic [XLEN-1:0]   alu_wdata,
  input  logic              lsu_valid,
  input  rv_pkg::reg_addr_t lsu_waddr,
  input  logic [XLEN-1:0]   lsu_wdata,
  output logic              lsu_ready,
  input  logic              iss_valid,
  input  rv_pkg::reg_addr_t iss_rd,
  output logic              iss_ready,
  input  rv_pkg::reg_addr_t dec_rs1,
  input  rv_pkg::reg_addr_t dec_rs2,
  input  rv_pkg::reg_addr_t dec_rd,
  output logic              dec_stall,
  output logic              pipe_hold,
  output logic              rf_we,
  output rv_pkg::reg_addr_t rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              proto_err
);
  import rv_pkg::*;
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  wb_state_t     state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          proto_err_q, proto_err_d;
  logic          alu_gnt, starve, at_limit, lsu_busy;
  always_comb begin
    pipe_hold = state_q == HOLD;
    alu_gnt = !pipe_hold && alu_we;
    lsu_ready = lsu_valid && !alu_gnt;
    rf_waddr = alu_gnt ? alu_waddr : lsu_waddr;
    rf_wdata = alu_gnt ? alu_wdata : lsu_wdata;
    rf_we = (alu_gnt || lsu_ready) && rf_waddr != '0;
    starve = !pipe_hold && lsu_valid && alu_we;
    at_limit = wait_q == WW'(STARVE_LIMIT - 1);
    state_d = (starve && at_limit) ? HOLD : NORMAL;
    wait_d = (pipe_hold || lsu_ready || (starve && at_limit)) ? '0 : starve ? wait_q + 1'b1 : wait_q;
    proto_err_d = proto_err_q | (pipe_hold && alu_we) | (lsu_ready && lsu_waddr != '0 && !lsu_busy);
    proto_err = proto_err_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= NORMAL;
      wait_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      proto_err_q <= proto_err_d;
    end
  rf_scoreboard #(.NREGS(NREGS), .MAX_OUTST(MAX_OUTST)) u_sb (
    .clk(clk), .reset_n(reset_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .lsu_grant(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_busy(lsu_busy),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_stall(dec_stall)
  );
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: per-cycle directed vectors with hand-computed outputs, plus reset and hold corner sequences.
module tb_regfile_wb_sched;
  logic        clk = 0, reset_n = 0;
  logic        alu_we = 0, lsu_valid = 0, iss_valid = 0;
  logic [4:0]  alu_waddr = 0, lsu_waddr = 0, iss_rd = 0, dec_rs1 = 0, dec_rs2 = 0, dec_rd = 0;
  logic [31:0] alu_wdata = 0, lsu_wdata = 0;
  logic        lsu_ready, iss_ready, dec_stall, pipe_hold, rf_we, proto_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  int n_chk = 0, n_fail = 0;

  regfile_wb_sched dut (
    .clk(clk), .reset_n(reset_n),
    .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_stall(dec_stall),
    .pipe_hold(pipe_hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic aw; logic [4:0] aa; logic [31:0] ad;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic iv; logic [4:0] ir;
    logic [4:0] r1, r2, rd;
    logic e_lr, e_ir, e_st, e_ph, e_we; logic [4:0] e_wa; logic [31:0] e_wd; logic e_pe;
  } vec_t;

  function automatic vec_t mk(input bit aw, input int aa, input logic [31:0] ad,
                              input bit lv, input int la, input logic [31:0] ld,
                              input bit iv, input int ir, input int r1, input int r2, input int rd,
                              input bit lr, input bit irdy, input bit st, input bit ph, input bit we,
                              input int wa, input logic [31:0] wd, input bit pe);
    vec_t v;
    v.aw = aw; v.aa = 5'(aa); v.ad = ad; v.lv = lv; v.la = 5'(la); v.ld = ld;
    v.iv = iv; v.ir = 5'(ir); v.r1 = 5'(r1); v.r2 = 5'(r2); v.rd = 5'(rd);
    v.e_lr = lr; v.e_ir = irdy; v.e_st = st; v.e_ph = ph; v.e_we = we;
    v.e_wa = 5'(wa); v.e_wd = wd; v.e_pe = pe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    @(negedge clk);
    alu_we = v.aw; alu_waddr = v.aa; alu_wdata = v.ad;
    lsu_valid = v.lv; lsu_waddr = v.la; lsu_wdata = v.ld;
    iss_valid = v.iv; iss_rd = v.ir; dec_rs1 = v.r1; dec_rs2 = v.r2; dec_rd = v.rd;
    #1;
    chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(v.e_lr));
    chk({tag, ".iss_ready"}, 32'(iss_ready), 32'(v.e_ir));
    chk({tag, ".dec_stall"}, 32'(dec_stall), 32'(v.e_st));
    chk({tag, ".pipe_hold"}, 32'(pipe_hold), 32'(v.e_ph));
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(v.e_we));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(v.e_wa));
    chk({tag, ".rf_wdata"}, rf_wdata, v.e_wd);
    chk({tag, ".proto_err"}, 32'(proto_err), 32'(v.e_pe));
  endtask

  vec_t tbl[$];

  initial begin
    // ALU only, then starve the LSU on reg 7 for four cycles and take the hold
    tbl.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0,0,  0,1,0,0,1,5,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 1,7, 0,0,0,  0,1,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,5,1, 1,7,32'h1234, 0,0, 7,0,0,  0,1,1,0,1,5,1,0));
    tbl.push_back(mk(0,0,0, 1,7,32'h1234, 0,0, 7,0,0,  1,1,0,1,1,7,32'h1234,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 7,0,0,  0,1,0,0,0,0,0,0));
    // scoreboard on reg 9: stall via rs1 and rd, bypass in grant cycle
    tbl.push_back(mk(0,0,0, 0,0,0, 1,9, 0,0,0,  0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 9,0,0,  0,1,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,9,  0,1,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,9,32'h99, 0,0, 9,0,0,  1,1,0,0,1,9,32'h99,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 9,9,0,  0,1,0,0,0,0,0,0));
    // x0 issue and writeback
    tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0,  0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,0,32'h55, 0,0, 0,0,0,  1,1,0,0,0,0,32'h55,0));
    // capacity: four issues fill it, grant+issue keeps it full
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(0,0,0, 0,0,0, 1,i, 0,0,0,  0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 1,10, 0,0,0,  0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,32'h11, 1,10, 0,0,0,  1,1,0,0,1,1,32'h11,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 1,11, 1,0,0,  0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,10,  0,0,1,0,0,0,0,0));
    // set beats clear on reg 2
    tbl.push_back(mk(0,0,0, 1,2,32'h22, 1,2, 0,0,0,  1,1,0,0,1,2,32'h22,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 2,0,0,  0,0,1,0,0,0,0,0));
    // write to non-busy reg 20 raises sticky proto_err
    tbl.push_back(mk(0,0,0, 1,20,32'h20, 0,0, 0,0,0,  1,1,0,0,1,20,32'h20,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,  0,1,0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,  0,1,0,0,0,0,0,1));

    repeat (2) @(negedge clk);
    #1;
    chk("rst.pipe_hold", 32'(pipe_hold), 0);
    chk("rst.iss_ready", 32'(iss_ready), 1);
    chk("rst.dec_stall", 32'(dec_stall), 0);
    chk("rst.lsu_ready", 32'(lsu_ready), 0);
    chk("rst.proto_err", 32'(proto_err), 0);
    chk("rst.rf_we", 32'(rf_we), 0);
    reset_n = 1;

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // fill to capacity, enter HOLD with reg 3 busy, then reset asynchronously mid-cycle
    run(mk(0,0,0, 0,0,0, 1,12, 0,0,0,  0,1,0,0,0,0,0,1), "fill");
    for (int i = 0; i < 4; i++)
      run(mk(1,5,1, 1,3,3, 0,0, 0,0,0,  0,0,0,0,1,5,1,1), $sformatf("stv%0d", i));
    run(mk(0,0,0, 0,0,0, 0,0, 3,0,0,  0,0,1,1,0,0,0,1), "hold");
    #1 reset_n = 0;
    #1;
    chk("amid.pipe_hold", 32'(pipe_hold), 0);
    chk("amid.dec_stall", 32'(dec_stall), 0);
    chk("amid.iss_ready", 32'(iss_ready), 1);
    chk("amid.proto_err", 32'(proto_err), 0);
    chk("amid.lsu_ready", 32'(lsu_ready), 0);
    #1 reset_n = 1;

    // ALU writing during HOLD is ignored and flagged; x0 LSU write does not hit the regfile
    for (int i = 0; i < 4; i++)
      run(mk(1,5,1, 1,0,32'h77, 0,0, 0,0,0,  0,1,0,0,1,5,1,0), $sformatf("stz%0d", i));
    run(mk(1,6,6, 1,0,32'h77, 0,0, 0,0,0,  1,1,0,1,0,0,32'h77,0), "holdalu");
    run(mk(0,0,0, 0,0,0, 0,0, 0,0,0,  0,1,0,0,0,0,0,1), "after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
